uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 57600, serial baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default PAR_NONE, of type uart_pkg::parity_t: PAR_NONE, PAR_ODD or PAR_EVEN.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit; the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit; reset, synchronous to clk, active-low.
REQ-008 SHALL have port rx_pin, input, 1 bit; asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data_ready, input, 1 bit; consumer accepts the held word.
REQ-010 SHALL have port rx_data, output, DATA_BITS wide; received word, LSB first on the line.
REQ-011 SHALL have port rx_data_valid, output, 1 bit; rx_data holds an unconsumed word.
REQ-012 SHALL have port rx_frame_err, output, 1 bit; status of the held word: a stop bit sampled low.
REQ-013 SHALL have port rx_parity_err, output, 1 bit; status of the held word: parity mismatch, always 0 when PARITY = PAR_NONE.
REQ-014 SHALL have port rx_overrun, output, 1 bit; one-cycle pulse when a completed word is dropped.
REQ-015 SHALL have port rx_busy, output, 1 bit; high in every state except IDLE.

Function
REQ-016 SHALL compute CYCLE = CLK_FRE/BAUD_RATE and size the bit-period counter at $clog2(CYCLE) bits.
REQ-017 SHALL pass rx_pin through a two-flop synchroniser and detect a start on the synchronised falling edge only.
REQ-018 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP, with transitions IDLE->START on edge, START->DATA, DATA->PARITY (PARITY != PAR_NONE) or DATA->STOP, PARITY->STOP, and STOP->IDLE.
REQ-019 SHALL sample each bit at counter value CYCLE/2-1 within its bit period.
REQ-020 SHALL, if the start bit samples high at mid-bit, treat it as a false start: return to IDLE with no output change.
REQ-021 SHALL leave DATA after DATA_BITS bit periods, assembling the word LSB first.
REQ-022 SHALL, in PARITY, compare the sampled bit with the XOR of the data bits (PAR_EVEN: sampled bit equals XOR; PAR_ODD: sampled bit equals inverted XOR).
REQ-023 SHALL sample every stop bit and set the frame error if any stop bit is low.
REQ-024 SHALL return to IDLE at the mid-sample of the last stop bit, so the next start edge is accepted half a bit early.
REQ-025 SHALL complete a frame in the cycle after the last stop mid-sample; at completion, if rx_data_valid=0 or rx_data_ready=1, it SHALL load rx_data and both error flags and set rx_data_valid=1.
REQ-026 SHALL, at completion with rx_data_valid=1 and rx_data_ready=0, keep the held word and flags unchanged and pulse rx_overrun for one cycle.
REQ-027 SHALL clear rx_data_valid in the cycle after rx_data_valid && rx_data_ready, unless a completion loads a new word in that same cycle.
REQ-028 SHALL keep receiving while a word is held; there is no stall state.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, set the FSM to IDLE, clear all counters, set both synchroniser flops to 1, and set rx_data=0, rx_data_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0.
REQ-030 SHALL, when reset is asserted mid-frame, discard the partial frame; the next frame needs a fresh falling edge after reset is released.

Configuration
REQ-031 SHALL, with UART_RX_MAJORITY_EN defined, decide each sampled bit as the 2-of-3 majority of the synchronised line at counter values CYCLE/2-2, CYCLE/2-1 and CYCLE/2.
REQ-032 SHALL, without UART_RX_MAJORITY_EN, use the single sample at CYCLE/2-1; timing of all outputs is identical in both builds.

Structure
REQ-033 SHALL place parity_t and the FSM state typedef in package uart_pkg.
REQ-034 SHALL place the synchroniser, falling-edge detector and optional majority filter in sub-module uart_rx_sync.

Verification
All scenarios use CLK_FRE=1_000_000 and BAUD_RATE=100_000, giving CYCLE=10.
REQ-035 SHALL cover: 8N1 byte 0xA5, rx_data_ready=1 -> rx_data=0xA5, valid for 1 cycle, both error flags 0.
REQ-036 SHALL cover: DATA_BITS=7, PAR_EVEN, frame 0x41 with a correct parity bit, then the same frame with the parity bit flipped -> rx_parity_err=0, then 1.
REQ-037 SHALL cover: stop bit driven low on byte 0x3C -> rx_data=0x3C, rx_frame_err=1.
REQ-038 SHALL cover: rx_data_ready=0 and two back-to-back frames 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses once.
REQ-039 SHALL cover: a low glitch of 3 cycles on an idle line -> false start, rx_data_valid stays 0 and rx_busy returns low.
REQ-040 SHALL cover: rst_n low during bit 4, then a frame 0x5A -> only 0x5A delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_ODD,
      PAR_EVEN
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser, falling-edge detector and bit decision.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote instead of a single sample.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_rx,
   output logic o_bit,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_fall = r_prev & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
   // r_sync1 is the value the synchronised line takes next cycle, so the vote
   // around the mid-sample point costs no extra latency.
   assign o_bit = majority3(r_prev, r_sync2, r_sync1);
`else
   assign o_bit = r_sync2;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (data bits, parity, stop bits) with a one-word holding register.
// Optional build macro UART_RX_MAJORITY_EN selects majority-vote bit sampling in uart_rx_sync.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int      CLK_FRE   = 50_000_000,
   parameter int      BAUD_RATE = 57600,
   parameter int      DATA_BITS = 8,
   parameter parity_t PARITY    = PAR_NONE,
   parameter int      STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_pin,
   input  logic                 rx_data_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int CYCLE = CLK_FRE / BAUD_RATE;
   localparam int CNT_W = $clog2(CYCLE);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CYCLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   rx_state_t            r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [3:0]           r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_frameErr;
   logic                 r_parityErr;
   logic                 r_done;
   logic                 r_busy;

   logic w_bit;
   logic w_fall;
   logic w_mid;
   logic w_last;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_rx   (rx_pin),
      .o_bit  (w_bit),
      .o_fall (w_fall)
   );

   assign w_mid  = (r_cnt == CNT_MID);
   assign w_last = (r_cnt == CNT_LAST);

   // Frame FSM: returns to idle at the last stop mid-sample and flags completion for the output stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_frameErr  <= 1'b0;
         r_parityErr <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               r_idx <= '0;
               if (w_fall) begin
                  r_state     <= ST_START;
                  r_busy      <= 1'b1;
                  r_frameErr  <= 1'b0;
                  r_parityErr <= 1'b0;
               end
            end
            ST_START: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_mid && w_bit) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_mid) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_idx == DATA_LAST) begin
                     r_idx   <= '0;
                     r_state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_mid) begin
                  r_parityErr <= (PARITY == PAR_EVEN) ? (w_bit != ^r_shift)
                                                      : (w_bit != ~^r_shift);
               end
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_mid && !w_bit) r_frameErr <= 1'b1;
               if (w_mid && (r_idx == STOP_LAST)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end else if (w_last) begin
                  r_cnt <= '0;
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: a completed word is dropped (with an overrun pulse) only if the old one is still unconsumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (r_done && (!rx_data_valid || rx_data_ready)) begin
            rx_data       <= r_shift;
            rx_frame_err  <= r_frameErr;
            rx_parity_err <= r_parityErr;
            rx_data_valid <= 1'b1;
         end else begin
            if (r_done) rx_overrun <= 1'b1;
            if (rx_data_valid && rx_data_ready) rx_data_valid <= 1'b0;
         end
      end
   end

   assign rx_busy = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed checks of an 8N1 and a 7E1 receiver against a frame-level model.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int CYCLE = 10;

   typedef struct packed {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
   } word_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx8   = 1'b1;
   logic       rx7   = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data8;
   logic [6:0] data7;
   logic       valid8, ferr8, perr8, ovr8, busy8;
   logic       valid7, ferr7, perr7, ovr7, busy7;

   int    testsRun    = 0;
   int    testsFailed = 0;
   int    ovr8Count   = 0;
   int    ovr7Count   = 0;
   word_t got8[$];
   word_t got7[$];

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .CLK_FRE(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
      .PARITY(PAR_NONE), .STOP_BITS(1)
   ) u_dut8 (
      .clk(clk), .rst_n(rst_n), .rx_pin(rx8), .rx_data_ready(ready),
      .rx_data(data8), .rx_data_valid(valid8), .rx_frame_err(ferr8),
      .rx_parity_err(perr8), .rx_overrun(ovr8), .rx_busy(busy8)
   );

   uart_rx_cfg #(
      .CLK_FRE(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
      .PARITY(PAR_EVEN), .STOP_BITS(1)
   ) u_dut7 (
      .clk(clk), .rst_n(rst_n), .rx_pin(rx7), .rx_data_ready(ready),
      .rx_data(data7), .rx_data_valid(valid7), .rx_frame_err(ferr7),
      .rx_parity_err(perr7), .rx_overrun(ovr7), .rx_busy(busy7)
   );

   // Collects every consumed word and every overrun pulse, sampled mid-period.
   always @(negedge clk) begin
      if (valid8 && ready) got8.push_back({1'b0, data8, ferr8, perr8});
      if (valid7 && ready) got7.push_back({2'b00, data7, ferr7, perr7});
      if (ovr8) ovr8Count++;
      if (ovr7) ovr7Count++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one frame on the chosen line; the 7-bit line carries an even parity bit.
   task automatic applyStimulus(input bit to7, input logic [8:0] data, input bit flipPar, input bit stopLow);
      logic bits[$];
      int   nData;
      nData = to7 ? 7 : 8;
      bits.push_back(1'b0);
      for (int i = 0; i < nData; i++) bits.push_back(data[i]);
      if (to7) bits.push_back((^data[6:0]) ^ flipPar);
      bits.push_back(~stopLow);
      foreach (bits[i]) begin
         if (to7) rx7 = bits[i];
         else     rx8 = bits[i];
         repeat (CYCLE) tick();
      end
      rx7 = 1'b1;
      rx8 = 1'b1;
   endtask

   task automatic checkFrame(input string tag, input bit to7, input word_t exp);
      word_t w;
      int    n;
      n = to7 ? got7.size() : got8.size();
      checkOutput({tag, " count"}, n, 1);
      if (n > 0) begin
         if (to7) w = got7.pop_front();
         else     w = got8.pop_front();
         checkOutput({tag, " data"}, w.data, exp.data);
         checkOutput({tag, " ferr"}, w.ferr, exp.ferr);
         checkOutput({tag, " perr"}, w.perr, exp.perr);
      end
      got7.delete();
      got8.delete();
   endtask

   task automatic sendAndCheck(input string tag, input bit to7, input logic [8:0] data,
                               input bit flipPar, input bit stopLow);
      word_t exp;
      applyStimulus(to7, data, flipPar, stopLow);
      repeat (2 * CYCLE) tick();
      exp.data = to7 ? {2'b00, data[6:0]} : {1'b0, data[7:0]};
      exp.ferr = stopLow;
      exp.perr = to7 ? flipPar : 1'b0;
      checkFrame(tag, to7, exp);
      checkOutput({tag, " valid after"}, to7 ? valid7 : valid8, 1'b0);
   endtask

   initial begin
      logic [8:0] d;
      bit         fp;
      bit         sl;

      rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("reset valid8", valid8, 1'b0);
      checkOutput("reset data8", data8, 8'h00);
      checkOutput("reset busy8", busy8, 1'b0);
      checkOutput("reset ferr8", ferr8, 1'b0);
      checkOutput("reset perr8", perr8, 1'b0);
      checkOutput("reset ovr8", ovr8, 1'b0);
      checkOutput("reset valid7", valid7, 1'b0);
      rst_n = 1'b1;
      repeat (5) tick();

      sendAndCheck("8N1 A5", 1'b0, 9'h0A5, 1'b0, 1'b0);
      checkOutput("busy idle", busy8, 1'b0);
      sendAndCheck("8N1 3C stop low", 1'b0, 9'h03C, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         d  = 9'($urandom_range(0, 255));
         sl = ($urandom_range(0, 3) == 0);
         sendAndCheck($sformatf("8N1 rand%0d", i), 1'b0, d, 1'b0, sl);
      end

      sendAndCheck("7E1 41 good", 1'b1, 9'h041, 1'b0, 1'b0);
      sendAndCheck("7E1 41 flipped", 1'b1, 9'h041, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         d  = 9'($urandom_range(0, 127));
         fp = $urandom_range(0, 1);
         sendAndCheck($sformatf("7E1 rand%0d", i), 1'b1, d, fp, 1'b0);
      end
      checkOutput("no overrun so far", ovr8Count + ovr7Count, 0);

      // Two back-to-back frames with the consumer stalled: first word held, second dropped.
      ready     = 1'b0;
      ovr8Count = 0;
      applyStimulus(1'b0, 9'h011, 1'b0, 1'b0);
      applyStimulus(1'b0, 9'h022, 1'b0, 1'b0);
      repeat (2 * CYCLE) tick();
      checkOutput("overrun held data", data8, 8'h11);
      checkOutput("overrun held valid", valid8, 1'b1);
      checkOutput("overrun held ferr", ferr8, 1'b0);
      checkOutput("overrun pulses", ovr8Count, 1);
      ready = 1'b1;
      repeat (2) tick();
      checkFrame("overrun drain", 1'b0, '{data: 9'h011, ferr: 1'b0, perr: 1'b0});
      checkOutput("overrun valid cleared", valid8, 1'b0);

      // Short low glitch on an idle line.
      rx8 = 1'b0;
      repeat (3) tick();
      rx8 = 1'b1;
      repeat (2) tick();
      checkOutput("glitch busy", busy8, 1'b1);
      repeat (2 * CYCLE) tick();
      checkOutput("glitch busy after", busy8, 1'b0);
      checkOutput("glitch valid", valid8, 1'b0);
      checkOutput("glitch no word", got8.size(), 0);

      // Reset during data bit 4 of 0xC3, then a clean 0x5A.
      d   = 9'h0C3;
      rx8 = 1'b0;
      repeat (CYCLE) tick();
      for (int i = 0; i < 4; i++) begin
         rx8 = d[i];
         repeat (CYCLE) tick();
      end
      rx8 = d[4];
      repeat (4) tick();
      rst_n = 1'b0;
      rx8   = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3 * CYCLE) tick();
      checkOutput("midreset busy", busy8, 1'b0);
      checkOutput("midreset no word", got8.size(), 0);
      sendAndCheck("after reset 5A", 1'b0, 9'h05A, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
